// File: rtl/gat_checker_pkg.sv
// Shared types and the tolerance compare for the GAT output checker.
// The mismatch record widths follow the checker's default NUM_CH/MAX_DEPTH/DATA_WIDTH.
package gat_checker_pkg;

    localparam int unsigned MM_CH_W  = 2;
    localparam int unsigned MM_IDX_W = 11;
    localparam int unsigned MM_DW    = 32;
    // Wide enough that dut - gold cannot overflow for any DATA_WIDTH below 64.
    localparam int unsigned CMP_W    = 64;

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    typedef struct packed {
        logic [MM_CH_W-1:0]  ch;
        logic [MM_IDX_W-1:0] idx;
        logic [MM_DW-1:0]    dut;
        logic [MM_DW-1:0]    gold;
    } mm_rec_t;

    function automatic logic abs_within_tol(input logic signed [CMP_W-1:0] dut,
                                            input logic signed [CMP_W-1:0] gold,
                                            input logic [CMP_W-1:0]        tol);
        logic signed [CMP_W-1:0] diff;
        logic [CMP_W-1:0]        mag;
        diff = dut - gold;
        mag  = diff[CMP_W-1] ? -diff : diff;
        return mag <= tol;
    endfunction

endpackage

// File: rtl/gat_output_checker_lane.sv
// One compare channel: golden RAM, sample index, two-stage compare and pass/fail/extra counts.
module gat_checker_lane
    import gat_checker_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned MAX_DEPTH  = 1024,
    parameter int unsigned ADDR_W     = $clog2(MAX_DEPTH),
    parameter int unsigned CNT_W      = $clog2(MAX_DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear,
    input  logic                  run,
    input  logic                  wr_en,
    input  logic [ADDR_W-1:0]     wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [CNT_W-1:0]      exp_cnt,
    input  logic [DATA_WIDTH-1:0] tol,
    input  logic                  vld,
    input  logic [DATA_WIDTH-1:0] data,
    output logic [CNT_W-1:0]      pass_cnt,
    output logic [CNT_W-1:0]      fail_cnt,
    output logic                  extra,
    output logic                  complete,
    output logic                  fail_evt,
    output logic [CNT_W-1:0]      evt_idx,
    output logic [DATA_WIDTH-1:0] evt_dut,
    output logic [DATA_WIDTH-1:0] evt_gold
);

    logic [DATA_WIDTH-1:0] mem [MAX_DEPTH];
    logic [DATA_WIDTH-1:0] gold_q;
    logic [CNT_W-1:0]      idx_q, exp_q, pass_q, fail_q, s1_idx_q;
    logic [DATA_WIDTH-1:0] tol_q, s1_dut_q;
    logic                  s1_vld_q, s1_extra_q, extra_q, take, ok;

    assign take = run && vld;

    // Golden memory is never reset so preloaded samples survive rst.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
        gold_q <= mem[idx_q[ADDR_W-1:0]];
    end

    assign ok = abs_within_tol(CMP_W'($signed(s1_dut_q)), CMP_W'($signed(gold_q)),
                               CMP_W'(tol_q));
    assign fail_evt = s1_vld_q && !s1_extra_q && !ok;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            idx_q      <= '0;
            pass_q     <= '0;
            fail_q     <= '0;
            extra_q    <= 1'b0;
            s1_vld_q   <= 1'b0;
            s1_extra_q <= 1'b0;
            s1_idx_q   <= '0;
            s1_dut_q   <= '0;
            exp_q      <= rst ? '0 : exp_cnt;
            tol_q      <= rst ? '0 : tol;
        end else begin
            s1_vld_q <= take;
            if (take) begin
                idx_q      <= (idx_q == '1) ? idx_q : idx_q + CNT_W'(1);
                s1_idx_q   <= idx_q;
                s1_dut_q   <= data;
                s1_extra_q <= idx_q >= exp_q;
                if (idx_q >= exp_q) extra_q <= 1'b1;
            end
            if (s1_vld_q && !s1_extra_q) begin
                if (ok) pass_q <= (pass_q == '1) ? pass_q : pass_q + CNT_W'(1);
                else    fail_q <= (fail_q == '1) ? fail_q : fail_q + CNT_W'(1);
            end
        end
    end

    assign complete = ((pass_q + fail_q) == exp_q) && !s1_vld_q;
    assign pass_cnt = pass_q;
    assign fail_cnt = fail_q;
    assign extra    = extra_q;
    assign evt_idx  = s1_idx_q;
    assign evt_dut  = s1_dut_q;
    assign evt_gold = gold_q;

endmodule

// File: rtl/gat_output_checker.sv
// Multi-channel GAT output checker: FSM, latency timers, first-fail capture.
// Optional mismatch FIFO built when GAT_CHECKER_MM_FIFO_EN is defined.
module gat_output_checker
    import gat_checker_pkg::*;
#(
    parameter int unsigned NUM_CH     = 4,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned MAX_DEPTH  = 1024,
    parameter int unsigned ADDR_W     = $clog2(MAX_DEPTH),
    parameter int unsigned CNT_W      = $clog2(MAX_DEPTH + 1),
    parameter int unsigned MM_DEPTH   = 16
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic                                    start,
    input  logic                                    gold_wr_en,
    input  logic [$clog2(NUM_CH)-1:0]               gold_wr_ch,
    input  logic [ADDR_W-1:0]                       gold_wr_addr,
    input  logic [DATA_WIDTH-1:0]                   gold_wr_data,
    input  logic [NUM_CH*CNT_W-1:0]                 exp_cnt,
    input  logic [NUM_CH*DATA_WIDTH-1:0]            tol,
    input  logic [31:0]                             timeout,
    input  logic [NUM_CH-1:0]                       dut_vld,
    input  logic [NUM_CH*DATA_WIDTH-1:0]            dut_data,
    output logic                                    busy,
    output logic                                    done,
    output logic                                    pass,
    output logic                                    timed_out,
    output logic [NUM_CH*CNT_W-1:0]                 pass_cnt,
    output logic [NUM_CH*CNT_W-1:0]                 fail_cnt,
    output logic [NUM_CH-1:0]                       extra,
    output logic                                    first_fail_vld,
    output logic [$clog2(NUM_CH)-1:0]               first_fail_ch,
    output logic [CNT_W-1:0]                        first_fail_idx,
    output logic [DATA_WIDTH-1:0]                   first_fail_dut,
    output logic [DATA_WIDTH-1:0]                   first_fail_gold,
    output logic [31:0]                             lat_first,
    output logic [31:0]                             lat_total,
    input  logic                                    mm_rd_en,
    output logic                                    mm_vld,
    output logic [$clog2(NUM_CH)+CNT_W+2*DATA_WIDTH-1:0] mm_dout
);

    localparam int unsigned CH_W = $clog2(NUM_CH);

    state_e              state_q;
    logic [31:0]         cyc_q, cyc_nxt, lat_first_q, lat_total_q;
    logic                first_seen_q, timed_out_q, ff_vld_q, start_acc, all_done, to_hit;
    logic                mm_ovf;
    mm_rec_t             ff_q;
    mm_rec_t             lane_rec [NUM_CH];
    logic [NUM_CH-1:0]   lane_complete, lane_fail_evt;
    logic [CH_W-1:0]     ff_sel;

    assign start_acc = start && (state_q != StRun);

    for (genvar g = 0; g < NUM_CH; g++) begin : g_lane
        logic [CNT_W-1:0]      evt_idx;
        logic [DATA_WIDTH-1:0] evt_dut, evt_gold;

        gat_checker_lane #(
            .DATA_WIDTH (DATA_WIDTH),
            .MAX_DEPTH  (MAX_DEPTH),
            .ADDR_W     (ADDR_W),
            .CNT_W      (CNT_W)
        ) u_lane (
            .clk      (clk),
            .rst      (rst),
            .clear    (start_acc),
            .run      (state_q == StRun),
            .wr_en    (gold_wr_en && (state_q != StRun) && (gold_wr_ch == CH_W'(g))),
            .wr_addr  (gold_wr_addr),
            .wr_data  (gold_wr_data),
            .exp_cnt  (exp_cnt[g*CNT_W +: CNT_W]),
            .tol      (tol[g*DATA_WIDTH +: DATA_WIDTH]),
            .vld      (dut_vld[g]),
            .data     (dut_data[g*DATA_WIDTH +: DATA_WIDTH]),
            .pass_cnt (pass_cnt[g*CNT_W +: CNT_W]),
            .fail_cnt (fail_cnt[g*CNT_W +: CNT_W]),
            .extra    (extra[g]),
            .complete (lane_complete[g]),
            .fail_evt (lane_fail_evt[g]),
            .evt_idx  (evt_idx),
            .evt_dut  (evt_dut),
            .evt_gold (evt_gold)
        );

        assign lane_rec[g] = '{ch: CH_W'(g), idx: evt_idx, dut: evt_dut, gold: evt_gold};
    end

    // Descending scan so the lowest failing channel wins.
    always_comb begin
        ff_sel = '0;
        for (int c = int'(NUM_CH) - 1; c >= 0; c--) begin
            if (lane_fail_evt[c]) ff_sel = CH_W'(c);
        end
    end

    assign all_done = &lane_complete;
    assign cyc_nxt  = cyc_q + 32'd1;
    assign to_hit   = (timeout != 32'd0) && (cyc_nxt >= timeout);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            cyc_q        <= '0;
            lat_first_q  <= '0;
            lat_total_q  <= '0;
            first_seen_q <= 1'b0;
            timed_out_q  <= 1'b0;
            ff_vld_q     <= 1'b0;
            ff_q         <= '0;
        end else begin
            if (|lane_fail_evt && !ff_vld_q) begin
                ff_vld_q <= 1'b1;
                ff_q     <= lane_rec[ff_sel];
            end
            unique case (state_q)
                StIdle, StDone: begin
                    if (start) begin
                        state_q      <= StRun;
                        cyc_q        <= 32'd1;
                        lat_first_q  <= '0;
                        lat_total_q  <= '0;
                        first_seen_q <= 1'b0;
                        timed_out_q  <= 1'b0;
                        ff_vld_q     <= 1'b0;
                        ff_q         <= '0;
                    end
                end
                StRun: begin
                    cyc_q <= cyc_nxt;
                    if (!first_seen_q && |dut_vld) begin
                        first_seen_q <= 1'b1;
                        lat_first_q  <= cyc_q;
                    end
                    if (all_done || to_hit) begin
                        state_q     <= StDone;
                        lat_total_q <= cyc_nxt;
                        timed_out_q <= !all_done;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

`ifdef GAT_CHECKER_MM_FIFO_EN
    localparam int unsigned PTR_W = $clog2(MM_DEPTH);

    mm_rec_t           mm_mem [MM_DEPTH];
    logic [PTR_W-1:0]  mm_wr_ptr_q, mm_rd_ptr_q;
    logic [PTR_W-1:0]  mm_slot [NUM_CH];
    logic [PTR_W:0]    mm_cnt_q, mm_n, mm_free;
    logic [NUM_CH-1:0] mm_we;
    logic              mm_drop, mm_pop, mm_ovf_q;

    assign mm_pop  = mm_rd_en && mm_vld;
    assign mm_free = (PTR_W + 1)'(MM_DEPTH) - mm_cnt_q;

    // Several channels may mismatch together; they take consecutive slots.
    always_comb begin
        mm_n    = '0;
        mm_we   = '0;
        mm_drop = 1'b0;
        for (int c = 0; c < int'(NUM_CH); c++) begin
            mm_slot[c] = mm_wr_ptr_q + mm_n[PTR_W-1:0];
            if (lane_fail_evt[c]) begin
                if (mm_n < mm_free) begin
                    mm_we[c] = 1'b1;
                    mm_n     = mm_n + (PTR_W + 1)'(1);
                end else begin
                    mm_drop = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int c = 0; c < int'(NUM_CH); c++) begin
            if (mm_we[c]) mm_mem[mm_slot[c]] <= lane_rec[c];
        end
    end

    always_ff @(posedge clk) begin
        if (rst || start_acc) begin
            mm_wr_ptr_q <= '0;
            mm_rd_ptr_q <= '0;
            mm_cnt_q    <= '0;
            mm_ovf_q    <= 1'b0;
        end else begin
            mm_wr_ptr_q <= mm_wr_ptr_q + mm_n[PTR_W-1:0];
            mm_rd_ptr_q <= mm_rd_ptr_q + PTR_W'(mm_pop);
            mm_cnt_q    <= mm_cnt_q + mm_n - (PTR_W + 1)'(mm_pop);
            if (mm_drop) mm_ovf_q <= 1'b1;
        end
    end

    assign mm_vld  = mm_cnt_q != '0;
    assign mm_dout = mm_vld ? mm_mem[mm_rd_ptr_q] : '0;
    assign mm_ovf  = mm_ovf_q;
`else
    logic unused_mm;
    assign unused_mm = mm_rd_en ^ MM_DEPTH[0];
    assign mm_vld    = 1'b0;
    assign mm_dout   = '0;
    assign mm_ovf    = 1'b0;
`endif

    assign busy            = state_q == StRun;
    assign done            = state_q == StDone;
    assign timed_out       = timed_out_q;
    assign pass            = done && (fail_cnt == '0) && (extra == '0) && !timed_out_q && !mm_ovf;
    assign first_fail_vld  = ff_vld_q;
    assign first_fail_ch   = ff_q.ch;
    assign first_fail_idx  = ff_q.idx;
    assign first_fail_dut  = ff_q.dut;
    assign first_fail_gold = ff_q.gold;
    assign lat_first       = lat_first_q;
    assign lat_total       = lat_total_q;

endmodule

// File: tb/tb_gat_output_checker.sv
// Directed self-checking bench for gat_output_checker (default 4 x 32-bit configuration).
module tb_gat_output_checker;

    localparam int NCH = 4;
    localparam int DW  = 32;
    localparam int CW  = 11;
    localparam int AW  = 10;

    logic              clk = 1'b0;
    logic              rst, start, gold_wr_en, mm_rd_en;
    logic [1:0]        gold_wr_ch;
    logic [AW-1:0]     gold_wr_addr;
    logic [DW-1:0]     gold_wr_data;
    logic [NCH*CW-1:0] exp_cnt;
    logic [NCH*DW-1:0] tol, dut_data;
    logic [31:0]       timeout;
    logic [NCH-1:0]    dut_vld;
    logic              busy, done, pass, timed_out, first_fail_vld, mm_vld;
    logic [NCH*CW-1:0] pass_cnt, fail_cnt;
    logic [NCH-1:0]    extra;
    logic [1:0]        first_fail_ch;
    logic [CW-1:0]     first_fail_idx;
    logic [DW-1:0]     first_fail_dut, first_fail_gold;
    logic [31:0]       lat_first, lat_total;
    logic [2+CW+2*DW-1:0] mm_dout;

    int n_chk = 0;
    int n_pass = 0;
    logic signed [DW-1:0] gold_m [NCH][32];

    gat_output_checker dut (
        .clk(clk), .rst(rst), .start(start), .gold_wr_en(gold_wr_en),
        .gold_wr_ch(gold_wr_ch), .gold_wr_addr(gold_wr_addr), .gold_wr_data(gold_wr_data),
        .exp_cnt(exp_cnt), .tol(tol), .timeout(timeout), .dut_vld(dut_vld),
        .dut_data(dut_data), .busy(busy), .done(done), .pass(pass), .timed_out(timed_out),
        .pass_cnt(pass_cnt), .fail_cnt(fail_cnt), .extra(extra),
        .first_fail_vld(first_fail_vld), .first_fail_ch(first_fail_ch),
        .first_fail_idx(first_fail_idx), .first_fail_dut(first_fail_dut),
        .first_fail_gold(first_fail_gold), .lat_first(lat_first), .lat_total(lat_total),
        .mm_rd_en(mm_rd_en), .mm_vld(mm_vld), .mm_dout(mm_dout)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    function automatic logic [CW-1:0] cnt_of(input logic [NCH*CW-1:0] v, input int ch);
        return v[ch*CW +: CW];
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic load_gold(input int ch, input int addr, input logic signed [DW-1:0] v);
        gold_wr_en   = 1'b1;
        gold_wr_ch   = 2'(ch);
        gold_wr_addr = AW'(addr);
        gold_wr_data = v;
        gold_m[ch][addr] = v;
        tick();
        gold_wr_en = 1'b0;
    endtask

    task automatic set_cfg(input logic [CW-1:0] e0, input logic [CW-1:0] e1,
                           input logic [CW-1:0] e2, input logic [CW-1:0] e3,
                           input logic [DW-1:0] t, input logic [31:0] to);
        exp_cnt = {e3, e2, e1, e0};
        tol     = {4{t}};
        timeout = to;
    endtask

    task automatic pulse_start;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic drive(input logic [3:0] v, input logic [DW-1:0] d0, input logic [DW-1:0] d1,
                         input logic [DW-1:0] d2, input logic [DW-1:0] d3);
        dut_vld  = v;
        dut_data = {d3, d2, d1, d0};
        tick();
        dut_vld = '0;
    endtask

    task automatic wait_done(input int max, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max && !ok; i++) begin
            if (done) ok = 1'b1;
            else tick();
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; start = 1'b0; gold_wr_en = 1'b0; mm_rd_en = 1'b0;
        gold_wr_ch = '0; gold_wr_addr = '0; gold_wr_data = '0;
        exp_cnt = '0; tol = '0; timeout = '0; dut_vld = '0; dut_data = '0;
        tick(); tick();
        rst = 1'b0;
        n_chk++; if (busy !== 1'b0 || done !== 1'b0 || pass !== 1'b0)
            $display("FAIL reset_state: busy=%b done=%b pass=%b want 000", busy, done, pass);
        else n_pass++;
        n_chk++; if (pass_cnt !== '0 || fail_cnt !== '0 || extra !== '0)
            $display("FAIL reset_counts: pass_cnt=%h fail_cnt=%h extra=%b want 0",
                     pass_cnt, fail_cnt, extra);
        else n_pass++;
        n_chk++; if (first_fail_vld !== 1'b0 || lat_total !== 32'd0 || mm_vld !== 1'b0)
            $display("FAIL reset_misc: ffv=%b lat_total=%0d mm_vld=%b want 0",
                     first_fail_vld, lat_total, mm_vld);
        else n_pass++;
        for (int c = 0; c < NCH; c++)
            for (int i = 0; i < 9; i++) load_gold(c, i, DW'((c - 2) * 100 + i * 3));
    endtask

    task automatic test_exact;
        set_cfg(8, 8, 8, 8, 0, 0);
        pulse_start();
        for (int i = 0; i < 8; i++) begin
            // A golden write during RUN must be ignored.
            if (i == 2) begin
                gold_wr_en = 1'b1; gold_wr_ch = 2'd0; gold_wr_addr = 10'd7;
                gold_wr_data = 32'd12345;
            end
            drive(4'hF, gold_m[0][i], gold_m[1][i], gold_m[2][i], gold_m[3][i]);
            gold_wr_en = 1'b0;
        end
        n_chk++; if (done !== 1'b0) $display("FAIL exact_done_t1: got %b want 0", done);
        else n_pass++;
        tick();
        n_chk++; if (done !== 1'b0) $display("FAIL exact_done_t2: got %b want 0", done);
        else n_pass++;
        tick();
        n_chk++; if (done !== 1'b1) $display("FAIL exact_done_t3: got %b want 1", done);
        else n_pass++;
        n_chk++; if (pass_cnt !== {4{11'd8}} || fail_cnt !== '0)
            $display("FAIL exact_counts: pass_cnt=%h fail_cnt=%h want %h 0",
                     pass_cnt, fail_cnt, {4{11'd8}});
        else n_pass++;
        n_chk++; if (pass !== 1'b1) $display("FAIL exact_pass: got %b want 1", pass);
        else n_pass++;
        n_chk++; if (lat_first !== 32'd1 || lat_total !== 32'd11)
            $display("FAIL exact_latency: first=%0d total=%0d want 1 11", lat_first, lat_total);
        else n_pass++;
    endtask

    task automatic test_tolerance;
        bit ok;
        load_gold(0, 0, 100); load_gold(0, 1, 100); load_gold(0, 2, 100);
        set_cfg(3, 0, 0, 0, 3, 0);
        pulse_start();
        drive(4'b0001, 103, 0, 0, 0);
        drive(4'b0001, 96, 0, 0, 0);
        drive(4'b0001, 97, 0, 0, 0);
        wait_done(10, ok);
        n_chk++; if (!ok) $display("FAIL tol_done: done=%b want 1 within 10 cycles", done);
        else n_pass++;
        n_chk++; if (cnt_of(pass_cnt, 0) !== 11'd2 || cnt_of(fail_cnt, 0) !== 11'd1)
            $display("FAIL tol_counts: pass=%0d fail=%0d want 2 1",
                     cnt_of(pass_cnt, 0), cnt_of(fail_cnt, 0));
        else n_pass++;
        n_chk++; if (first_fail_vld !== 1'b1 || first_fail_idx !== 11'd1 ||
                     first_fail_dut !== 32'd96 || first_fail_gold !== 32'd100)
            $display("FAIL tol_first_fail: vld=%b idx=%0d dut=%0d gold=%0d want 1 1 96 100",
                     first_fail_vld, first_fail_idx, first_fail_dut, first_fail_gold);
        else n_pass++;
        n_chk++; if (pass !== 1'b0) $display("FAIL tol_pass: got %b want 0", pass);
        else n_pass++;
    endtask

    task automatic test_simultaneous;
        bit ok;
        logic [DW-1:0] d [NCH];
        set_cfg(8, 8, 8, 8, 0, 0);
        pulse_start();
        for (int i = 0; i < 8; i++) begin
            for (int c = 0; c < NCH; c++) d[c] = gold_m[c][i];
            if (i == 5) begin d[1] = d[1] + 1; d[2] = d[2] + 1; end
            if (i == 6) d[3] = d[3] + 1;
            start = (i == 3); // ignored while running
            drive(4'hF, d[0], d[1], d[2], d[3]);
            start = 1'b0;
        end
        wait_done(10, ok);
        n_chk++; if (!ok) $display("FAIL simul_done: done=%b want 1 within 10 cycles", done);
        else n_pass++;
        n_chk++; if (first_fail_ch !== 2'd1 || first_fail_idx !== 11'd5)
            $display("FAIL simul_first_fail: ch=%0d idx=%0d want 1 5",
                     first_fail_ch, first_fail_idx);
        else n_pass++;
        n_chk++; if (first_fail_dut !== DW'(gold_m[1][5] + 1) || first_fail_gold !== gold_m[1][5])
            $display("FAIL simul_ff_data: dut=%0d gold=%0d want %0d %0d", first_fail_dut,
                     first_fail_gold, gold_m[1][5] + 1, gold_m[1][5]);
        else n_pass++;
        n_chk++; if (fail_cnt !== {11'd1, 11'd1, 11'd1, 11'd0} ||
                     pass_cnt !== {11'd7, 11'd7, 11'd7, 11'd8})
            $display("FAIL simul_counts: pass_cnt=%h fail_cnt=%h", pass_cnt, fail_cnt);
        else n_pass++;
    endtask

    task automatic test_extra;
        bit ok;
        set_cfg(0, 8, 8, 8, 0, 0);
        pulse_start();
        for (int i = 0; i < 9; i++)
            drive({1'b1, i < 8, i < 8, i == 0}, 0, gold_m[1][i], gold_m[2][i], gold_m[3][i]);
        wait_done(10, ok);
        n_chk++; if (!ok) $display("FAIL extra_done: done=%b want 1 within 10 cycles", done);
        else n_pass++;
        n_chk++; if (extra !== 4'b1001) $display("FAIL extra_flags: got %b want 1001", extra);
        else n_pass++;
        n_chk++; if (pass !== 1'b0) $display("FAIL extra_pass: got %b want 0", pass);
        else n_pass++;
        n_chk++; if (cnt_of(pass_cnt, 3) !== 11'd8 || cnt_of(pass_cnt, 0) !== 11'd0 ||
                     cnt_of(fail_cnt, 0) !== 11'd0)
            $display("FAIL extra_counts: ch3 pass=%0d ch0 pass=%0d fail=%0d want 8 0 0",
                     cnt_of(pass_cnt, 3), cnt_of(pass_cnt, 0), cnt_of(fail_cnt, 0));
        else n_pass++;
    endtask

    task automatic test_timeout;
        set_cfg(8, 0, 0, 0, 0, 50);
        pulse_start();
        for (int i = 0; i < 3; i++) drive(4'b0001, gold_m[0][i], 0, 0, 0);
        for (int i = 4; i < 49; i++) tick();
        n_chk++; if (done !== 1'b0) $display("FAIL timeout_early: done=%b at cycle 49 want 0", done);
        else n_pass++;
        tick();
        n_chk++; if (done !== 1'b1 || timed_out !== 1'b1)
            $display("FAIL timeout_fire: done=%b timed_out=%b at cycle 50 want 1 1",
                     done, timed_out);
        else n_pass++;
        n_chk++; if (lat_total !== 32'd50) $display("FAIL timeout_lat: got %0d want 50", lat_total);
        else n_pass++;
        n_chk++; if (cnt_of(pass_cnt, 0) !== 11'd3 || pass !== 1'b0)
            $display("FAIL timeout_counts: pass_cnt=%0d pass=%b want 3 0",
                     cnt_of(pass_cnt, 0), pass);
        else n_pass++;
    endtask

    task automatic test_reset_midrun;
        bit ok;
        set_cfg(8, 8, 8, 8, 0, 0);
        pulse_start();
        for (int i = 0; i < 4; i++)
            drive(4'hF, gold_m[0][i], gold_m[1][i], gold_m[2][i], gold_m[3][i]);
        rst = 1'b1;
        drive(4'hF, gold_m[0][4], gold_m[1][4], gold_m[2][4], gold_m[3][4]);
        rst = 1'b0;
        tick();
        n_chk++; if (busy !== 1'b0 || done !== 1'b0 || pass_cnt !== '0 || lat_first !== 32'd0)
            $display("FAIL rst_midrun: busy=%b done=%b pass_cnt=%h lat_first=%0d want 0",
                     busy, done, pass_cnt, lat_first);
        else n_pass++;
        // Golden contents survive reset.
        set_cfg(1, 0, 0, 0, 0, 0);
        pulse_start();
        drive(4'b0001, gold_m[0][0], 0, 0, 0);
        wait_done(10, ok);
        n_chk++; if (!ok || pass !== 1'b1 || cnt_of(pass_cnt, 0) !== 11'd1)
            $display("FAIL rst_gold_kept: done=%b pass=%b pass_cnt=%0d want 1 1 1",
                     done, pass, cnt_of(pass_cnt, 0));
        else n_pass++;
    endtask

`ifdef GAT_CHECKER_MM_FIFO_EN
    task automatic test_fifo;
        bit ok;
        logic [2+CW+2*DW-1:0] want;
        for (int i = 0; i < 20; i++) load_gold(0, i, DW'(i));
        set_cfg(20, 0, 0, 0, 0, 0);
        pulse_start();
        for (int i = 0; i < 20; i++) drive(4'b0001, DW'(i + 1000), 0, 0, 0);
        wait_done(10, ok);
        n_chk++; if (!ok || pass !== 1'b0) $display("FAIL fifo_done: done=%b pass=%b", done, pass);
        else n_pass++;
        for (int i = 0; i < 16; i++) begin
            want = {2'd0, CW'(i), DW'(i + 1000), DW'(i)};
            n_chk++; if (mm_vld !== 1'b1 || mm_dout !== want)
                $display("FAIL fifo_pop%0d: vld=%b dout=%h want 1 %h", i, mm_vld, mm_dout, want);
            else n_pass++;
            mm_rd_en = 1'b1;
            tick();
            mm_rd_en = 1'b0;
        end
        n_chk++; if (mm_vld !== 1'b0) $display("FAIL fifo_empty: mm_vld=%b want 0", mm_vld);
        else n_pass++;
    endtask
`endif

    initial begin
        test_reset();
        test_exact();
        test_tolerance();
        test_simultaneous();
        test_extra();
        test_timeout();
        test_reset_midrun();
`ifdef GAT_CHECKER_MM_FIFO_EN
        test_fifo();
`endif
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/gat_output_checker.md
# gat_output_checker

Synthesizable multi-channel self-check block for on-FPGA GAT layer bring-up. It compares up to NUM_CH DUT output streams (for example WH, DMVM coefficient, softmax alpha and aggregator feature) against golden samples preloaded into per-channel memories. It applies a per-channel absolute tolerance, keeps pass/fail counts, captures the first mismatch, and measures first-output and total latency. It sits beside gat_top, tapping each stage's valid/data pair, and is read back by the host after `done`.

## Interface
- NUM_CH, 4, number of compared streams
- DATA_WIDTH, 32, signed sample width, identical for all channels
- MAX_DEPTH, 1024, golden samples per channel
- ADDR_W, $clog2(MAX_DEPTH), golden address width
- CNT_W, $clog2(MAX_DEPTH+1), sample counter width
- MM_DEPTH, 16, mismatch FIFO depth (only used with the macro)

Ports:
- clk  in  1  single clock
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse; begins a run
- gold_wr_en  in  1  golden write strobe
- gold_wr_ch  in  $clog2(NUM_CH)  target channel
- gold_wr_addr  in  ADDR_W  sample index
- gold_wr_data  in  DATA_WIDTH  golden sample
- exp_cnt  in  NUM_CH*CNT_W  expected samples per channel; sampled at start
- tol  in  NUM_CH*DATA_WIDTH  unsigned absolute tolerance per channel; sampled at start
- timeout  in  32  run limit in cycles; 0 disables
- dut_vld  in  NUM_CH  per-channel sample valid
- dut_data  in  NUM_CH*DATA_WIDTH  per-channel signed samples
- busy  out  1  high in RUN
- done  out  1  level, high in DONE
- pass  out  1  done, no fails, no extras, no timeout
- timed_out  out  1  run ended by timeout
- pass_cnt, fail_cnt  out  NUM_CH*CNT_W  per-channel counts
- extra  out  NUM_CH  channel received more than exp_cnt samples
- first_fail_vld  out  1  a mismatch was captured
- first_fail_ch  out  $clog2(NUM_CH)
- first_fail_idx  out  CNT_W
- first_fail_dut, first_fail_gold  out  DATA_WIDTH
- lat_first  out  32  cycles from start to the first dut_vld on any channel
- lat_total  out  32  cycles from start to DONE entry
- mm_rd_en  in  1  pop mismatch FIFO
- mm_vld  out  1  FIFO non-empty
- mm_dout  out  $clog2(NUM_CH)+CNT_W+2*DATA_WIDTH  {ch, idx, dut, gold}

## Operation
- FSM states: IDLE, RUN, DONE.
  - IDLE to RUN on start.
  - RUN to DONE when every channel's count equals exp_cnt and the pipeline is empty, or when the cycle counter equals a non-zero timeout.
  - DONE to RUN on start.
- start clears all counters, flags, latencies and the FIFO; it is ignored in RUN.
- gold_wr_en is accepted only in IDLE and DONE; it is ignored in RUN.
- Comparison per sample: diff = dut - gold, computed at DATA_WIDTH+1 bits signed.
  - The sample passes when |diff| <= zero-extended tol.
  - tol=0 means exact match.
- Sample index is the per-channel received count. A sample at index >= exp_cnt is not compared and sets extra[ch].
- A channel with exp_cnt=0 is complete at start.
- All channels compare in parallel. When several channels mismatch in the same cycle, the first-fail capture takes the lowest channel.
- The first-fail registers capture only once per run.
- The counters saturate at all-ones.
- rst returns every output to 0 and the FSM to IDLE. Golden memory contents are retained and not cleared.

## Timing
- dut_vld at cycle t:
  - golden read issued at t
  - compare at t+1
  - pass_cnt/fail_cnt/first_fail update visible at t+2
- done rises the cycle after the last expected sample's counter update, i.e. at t+3 for the final sample.
- lat_total is latched on DONE entry.
- lat_first is latched on the first cycle any dut_vld is high in RUN, counting start as cycle 0.
- A timeout fires on cycle timeout after start. In-flight samples still complete their counter update.
- Outputs hold their values in DONE until the next start or rst.

## Configuration
- GAT_CHECKER_MM_FIFO_EN defined:
  - every mismatch is pushed into an MM_DEPTH FIFO.
  - When full, further pushes are dropped and a sticky internal overflow bit forces pass=0.
  - mm_rd_en pops the FIFO; mm_dout is valid while mm_vld is high.
- Not defined:
  - no FIFO is built; only the first-fail registers exist.
  - mm_vld and mm_dout are tied to 0 and mm_rd_en is ignored.

## Structure
- Package gat_checker_pkg holds:
  - the state enum
  - the mismatch record struct {ch, idx, dut, gold}
  - the abs-diff compare function
- Sub-module gat_checker_lane is instantiated NUM_CH times. Each lane contains:
  - a golden RAM
  - an index counter
  - the compare pipeline
  - pass/fail/extra tracking
- The top level contains the FSM, the latency timers, first-fail arbitration and the optional FIFO.

## Test plan
- Exact match: NUM_CH=4, exp_cnt=8 each, tol=0, data equal to golden.
  - Required: pass_cnt=8 on every channel, pass=1, done at last vld+3.
- Tolerance: golden 100, dut 103, tol=3 passes; dut 96, tol=3 fails.
  - Required: fail_cnt=1 and first_fail_idx matches the failing sample index.
- Simultaneous mismatch: ch2 and ch1 both fail in the same cycle at index 5.
  - Required: first_fail_ch=1, first_fail_idx=5.
- Extra and empty channel: ch0 exp_cnt=0 with 1 sample sent, ch3 receives 9 samples with exp_cnt=8.
  - Required: extra=4'b1001, pass=0.
- Timeout: timeout=50 and ch0 sends only 3 of 8 samples.
  - Required: timed_out=1, done at cycle 50, lat_total=50.
- Reset mid-run and FIFO (GAT_CHECKER_MM_FIFO_EN):
  - 20 mismatches with MM_DEPTH=16: the first 16 are popped in order and pass=0.
  - rst at sample 4 returns all outputs to 0 and the FSM to IDLE.
